// File: rtl/kong_throw_ctrl.sv
// kong_throw_ctrl
//   Kong animation and barrel-throw sequencer. Kong steps through
//   NORMAL -> GET -> HOLD -> DROP. The time spent in each phase is a number of
//   frame ticks. In HOLD, each barrel goes to the barrel spawner over a
//   drop_req/drop_ack handshake, so Kong waits in HOLD while the spawner is full.
//
// Ports
//   clk, rst         system clock; asynchronous active-high reset
//   start            level; leave IDLE
//   over             level; game over, return to IDLE (beats every other event)
//   pause            level; freeze phase counter, FSM and handshake
//   tick             single-cycle frame enable that drives phase timing
//   drop_ack         spawner accepts the barrel (looked at only while drop_req=1)
//   drop_req         a barrel is ready for the spawner; held until acknowledged
//   is_drop          single-cycle pulse on the cycle after a completed handshake
//   x, y             constant sprite position
//   state            0 = INITIAL (IDLE), 1 = PLAYING
//   animation_state  00 NORMAL, 01 GET, 10 HOLD, 11 DROP
//   throw_count      barrels handed off since leaving IDLE; wraps silently
module kong_throw_ctrl #(
  parameter int unsigned KONG_X       = 127,
  parameter int unsigned KONG_Y       = 79,
  parameter int unsigned NORMAL_TICKS = 80,
  parameter int unsigned GET_TICKS    = 16,
  parameter int unsigned HOLD_TICKS   = 16,
  parameter int unsigned DROP_TICKS   = 16,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned THROW_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               over,
  input  logic               pause,
  input  logic               tick,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               is_drop,
  output logic [9:0]         x,
  output logic [8:0]         y,
  output logic               state,
  output logic [1:0]         animation_state,
  output logic [THROW_W-1:0] throw_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORMAL,
    S_GET,
    S_HOLD,
    S_DROP
  } fsm_t;

  localparam logic [CNT_W-1:0] NORMAL_LAST = CNT_W'(NORMAL_TICKS - 1);
  localparam logic [CNT_W-1:0] GET_LAST    = CNT_W'(GET_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_TICKS - 1);

  fsm_t               fsm, fsm_n;
  logic [CNT_W-1:0]   cnt, cnt_n, last;
  logic               req_n, is_drop_n, state_n;
  logic [1:0]         anim_n;
  logic [THROW_W-1:0] throw_n;

  assign x = 10'(KONG_X);
  assign y = 9'(KONG_Y);

  always_comb begin
    case (fsm)
      S_NORMAL: last = NORMAL_LAST;
      S_GET:    last = GET_LAST;
      S_HOLD:   last = HOLD_LAST;
      S_DROP:   last = DROP_LAST;
      default:  last = '0;
    endcase
  end

  always_comb begin
    fsm_n     = fsm;
    cnt_n     = cnt;
    req_n     = drop_req;
    throw_n   = throw_count;
    is_drop_n = 1'b0;

    if (fsm == S_IDLE) begin
      if (start) begin
        fsm_n   = S_NORMAL;
        cnt_n   = '0;
        req_n   = 1'b0;
        throw_n = '0;
      end
    end else if (over) begin
      fsm_n = S_IDLE;
      cnt_n = '0;
      req_n = 1'b0;
    end else if (!pause) begin
      if (fsm == S_HOLD && drop_req) begin
        // Once the barrel is offered, ticks no longer matter; only the ack does.
        if (drop_ack) begin
          fsm_n     = S_DROP;
          cnt_n     = '0;
          req_n     = 1'b0;
          is_drop_n = 1'b1;
          throw_n   = throw_count + THROW_W'(1);
        end
      end else if (tick) begin
        if (cnt == last) begin
          case (fsm)
            S_NORMAL: begin fsm_n = S_GET;    cnt_n = '0; end
            S_GET:    begin fsm_n = S_HOLD;   cnt_n = '0; end
            // The HOLD advance tick offers the barrel instead of leaving HOLD;
            // the counter stays parked at its last value.
            S_HOLD:   req_n = 1'b1;
            S_DROP:   begin fsm_n = S_NORMAL; cnt_n = '0; end
            default:  fsm_n = S_IDLE;
          endcase
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
  end

  // The visible status is decoded from the next FSM value and then registered.
  // This keeps it in step with the FSM and keeps the outputs glitch-free.
  always_comb begin
    state_n = 1'b1;
    case (fsm_n)
      S_NORMAL: anim_n = 2'b00;
      S_GET:    anim_n = 2'b01;
      S_HOLD:   anim_n = 2'b10;
      S_DROP:   anim_n = 2'b11;
      default: begin
        anim_n  = 2'b00;
        state_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm             <= S_IDLE;
      cnt             <= '0;
      drop_req        <= 1'b0;
      is_drop         <= 1'b0;
      throw_count     <= '0;
      state           <= 1'b0;
      animation_state <= 2'b00;
    end else begin
      fsm             <= fsm_n;
      cnt             <= cnt_n;
      drop_req        <= req_n;
      is_drop         <= is_drop_n;
      throw_count     <= throw_n;
      state           <= state_n;
      animation_state <= anim_n;
    end
  end

endmodule
